// File: rtl/pc_redirect_if.sv
`default_nettype none
// ============================================================================
// pc_redirect_if : F-stage PC control bundle (redirect requests in, fetch PC out)
// Revision 1.0
// ============================================================================
interface pc_redirect_if #(
  parameter int WIDTH = 32
);
  logic             enable_PC;
  logic             br_valid;
  logic [WIDTH-1:0] br_target;
  logic             exc_req;
  logic             eret_req;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_seq;
  logic             pend_valid;
  logic             fetch_exc;

  // Pipeline/control side: issues redirects, consumes the fetch PC.
  modport master (
    output enable_PC, br_valid, br_target, exc_req, eret_req, epc,
    input  pc, pc_seq, pend_valid, fetch_exc
  );

  // PC unit side.
  modport slave (
    input  enable_PC, br_valid, br_target, exc_req, eret_req, epc,
    output pc, pc_seq, pend_valid, fetch_exc
  );
endinterface
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// pc_redirect_unit : fetch-PC register with prioritised redirects and a
//                    one-entry branch buffer for redirects arriving in a stall.
// Optional macro PC_RANGE_CHECK_EN enables the fetch_exc address check.
// Revision 1.0
// ============================================================================
module pc_redirect_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_4180,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] ADDR_LO      = 32'h0000_3000,
  parameter logic [WIDTH-1:0] ADDR_HI      = 32'h0000_6ffc
) (
  input  wire         clk,
  input  wire         reset,
  pc_redirect_if.slave bus
);

  localparam logic [WIDTH-1:0] c_step = WIDTH'(STEP);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pend_target;
  logic             r_pend_valid;
  logic [WIDTH-1:0] w_pc_seq;

  assign w_pc_seq = r_pc + c_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_VECTOR;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (bus.exc_req) begin
      r_pc         <= EXC_VECTOR;
      r_pend_valid <= 1'b0;
    end else if (bus.eret_req) begin
      r_pc         <= bus.epc;
      r_pend_valid <= 1'b0;
    end else if (bus.enable_PC) begin
      r_pend_valid <= 1'b0;
      if (bus.br_valid)
        r_pc <= bus.br_target;
      else if (r_pend_valid)
        r_pc <= r_pend_target;
      else
        r_pc <= w_pc_seq;
    end else if (bus.br_valid) begin
      // Stalled: remember the newest redirect until the pipeline moves again.
      r_pend_target <= bus.br_target;
      r_pend_valid  <= 1'b1;
    end
  end

  assign bus.pc         = r_pc;
  assign bus.pc_seq     = w_pc_seq;
  assign bus.pend_valid = r_pend_valid;

`ifdef PC_RANGE_CHECK_EN
  assign bus.fetch_exc = !reset &&
                         ((r_pc[1:0] != 2'b00) || (r_pc < ADDR_LO) || (r_pc > ADDR_HI));
`else
  // Range bounds stay referenced so both builds share one parameter list.
  assign bus.fetch_exc = 1'b0 & (ADDR_HI < ADDR_LO);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_redirect_unit : directed bench for pc_redirect_unit
// Revision 1.0
// ============================================================================
module tb_pc_redirect_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pc_redirect_if #(.WIDTH(32)) bus ();

  pc_redirect_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PC_RANGE_CHECK_EN
  localparam logic c_rc = 1'b1;
`else
  localparam logic c_rc = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br_to(input logic [31:0] tgt);
    bus.enable_PC = 1'b1;
    bus.br_valid  = 1'b1;
    bus.br_target = tgt;
    tick();
    bus.br_valid  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset         = 1'b1;
    bus.enable_PC = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_target = '0;
    bus.exc_req   = 1'b0;
    bus.eret_req  = 1'b0;
    bus.epc       = '0;

    // T1: reset and sequential fetch
    #12;
    check("rst_pc", bus.pc, 32'h3000);
    check("rst_pend", {31'd0, bus.pend_valid}, 32'd0);
    check("rst_fexc", {31'd0, bus.fetch_exc}, 32'd0);
    #10 reset = 1'b0;
    check("post_rst_pc", bus.pc, 32'h3000);
    bus.enable_PC = 1'b1;
    tick(); check("seq1", bus.pc, 32'h3004);
    tick(); check("seq2", bus.pc, 32'h3008);
    tick(); check("seq3", bus.pc, 32'h300c);
    check("seq_pcseq", bus.pc_seq, 32'h3010);
    check("seq_pend", {31'd0, bus.pend_valid}, 32'd0);

    // T2: branch buffered during a 2-cycle stall
    bus.enable_PC = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h3100;
    tick();
    bus.br_valid  = 1'b0;
    check("t2_hold1", bus.pc, 32'h300c);
    check("t2_pend1", {31'd0, bus.pend_valid}, 32'd1);
    tick();
    check("t2_hold2", bus.pc, 32'h300c);
    check("t2_pend2", {31'd0, bus.pend_valid}, 32'd1);
    bus.enable_PC = 1'b1;
    tick();
    check("t2_release", bus.pc, 32'h3100);
    check("t2_pend_clr", {31'd0, bus.pend_valid}, 32'd0);
    tick();
    check("t2_seq", bus.pc, 32'h3104);

    // T3: newest buffered branch wins; exception clears the buffer
    bus.enable_PC = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h3100;
    tick();
    bus.br_target = 32'h3200;
    tick();
    bus.br_valid  = 1'b0;
    check("t3_hold", bus.pc, 32'h3104);
    bus.enable_PC = 1'b1;
    tick();
    check("t3_newest", bus.pc, 32'h3200);
    bus.enable_PC = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h3300;
    tick();
    bus.br_valid  = 1'b0;
    check("t3_pend", {31'd0, bus.pend_valid}, 32'd1);
    bus.exc_req   = 1'b1;
    tick();
    bus.exc_req   = 1'b0;
    check("t3_exc_pc", bus.pc, 32'h4180);
    check("t3_exc_pend", {31'd0, bus.pend_valid}, 32'd0);
    tick();
    check("t3_exc_nopend", bus.pc, 32'h4180);

    // Live branch on release beats the buffered one
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h3400;
    tick();
    bus.enable_PC = 1'b1;
    bus.br_target = 32'h3500;
    tick();
    bus.br_valid  = 1'b0;
    check("live_wins", bus.pc, 32'h3500);
    check("live_pend", {31'd0, bus.pend_valid}, 32'd0);
    tick();
    check("live_seq", bus.pc, 32'h3504);

    // T4: exc beats eret; eret ignores stall and clears buffer
    bus.enable_PC = 1'b0;
    bus.exc_req   = 1'b1;
    bus.eret_req  = 1'b1;
    bus.epc       = 32'h3010;
    tick();
    bus.exc_req   = 1'b0;
    check("t4_exc_pri", bus.pc, 32'h4180);
    tick();
    bus.eret_req  = 1'b0;
    check("t4_eret", bus.pc, 32'h3010);
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h3600;
    tick();
    bus.br_valid  = 1'b0;
    bus.eret_req  = 1'b1;
    bus.epc       = 32'h3020;
    tick();
    bus.eret_req  = 1'b0;
    check("t4_eret2", bus.pc, 32'h3020);
    check("t4_eret_pend", {31'd0, bus.pend_valid}, 32'd0);

    // T5: wrap-around
    br_to(32'hffff_fffc);
    check("t5_top", bus.pc, 32'hffff_fffc);
    check("t5_pcseq", bus.pc_seq, 32'h0);
    check("t5_fexc_top", {31'd0, bus.fetch_exc}, {31'd0, c_rc});
    tick();
    check("t5_wrap", bus.pc, 32'h0);
    check("t5_fexc_zero", {31'd0, bus.fetch_exc}, {31'd0, c_rc});

    // T6: range check boundaries
    br_to(32'h3002); check("t6_misalign", {31'd0, bus.fetch_exc}, {31'd0, c_rc});
    br_to(32'h7000); check("t6_above",    {31'd0, bus.fetch_exc}, {31'd0, c_rc});
    br_to(32'h2ffc); check("t6_below",    {31'd0, bus.fetch_exc}, {31'd0, c_rc});
    br_to(32'h3004); check("t6_legal",    {31'd0, bus.fetch_exc}, 32'd0);
    br_to(32'h6ffc); check("t6_hi_edge",  {31'd0, bus.fetch_exc}, 32'd0);
    br_to(32'h3000); check("t6_lo_edge",  {31'd0, bus.fetch_exc}, 32'd0);

    // Async reset mid-stall discards pending redirect
    bus.enable_PC = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h3700;
    tick();
    bus.br_valid  = 1'b0;
    check("ar_pend", {31'd0, bus.pend_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("ar_pc", bus.pc, 32'h3000);
    check("ar_pend_clr", {31'd0, bus.pend_valid}, 32'd0);
    #1 reset = 1'b0;
    bus.enable_PC = 1'b1;
    tick();
    check("ar_seq", bus.pc, 32'h3004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
